// File: rtl/gbe_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a 10GbE tx core, with truncation of over-long packets.
// Optional per-requester packet counters are enabled by defining GBE_TX_ARBITER_PKTCNT_EN.
module gbe_tx_arbiter #(
    parameter int DATA_W    = 64,
    parameter int MAX_WORDS = 1024
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              valid0,
    input  logic              valid1,
    input  logic              eof0,
    input  logic              eof1,
    input  logic [31:0]       ip0,
    input  logic [31:0]       ip1,
    input  logic [15:0]       port0,
    input  logic [15:0]       port1,
    output logic              grant0,
    output logic              grant1,
    output logic              ready0,
    output logic              ready1,
    input  logic              gbe_tx_afull,
    output logic [DATA_W-1:0] gbe_tx_data,
    output logic              gbe_tx_valid,
    output logic              gbe_tx_end_of_frame,
    output logic [31:0]       gbe_tx_dest_ip,
    output logic [15:0]       gbe_tx_dest_port,
    input  logic              ctr_rst,
    output logic [31:0]       txvldctr,
    output logic [15:0]       trunc_ctr
`ifdef GBE_TX_ARBITER_PKTCNT_EN
    ,
    output logic [31:0]       pktcnt0,
    output logic [31:0]       pktcnt1
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [31:0]       ip_q, ip_d;
    logic [15:0]       port_q, port_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_eof_q, tx_eof_d;
    logic [31:0]       txvldctr_q;
    logic [15:0]       trunc_ctr_q;
    logic              trunc_inc;

    logic              own_valid, own_eof, granted, acc, at_limit, pkt_end;
    logic [DATA_W-1:0] own_data;

    assign own_valid = owner_q ? valid1 : valid0;
    assign own_eof   = owner_q ? eof1 : eof0;
    assign own_data  = owner_q ? data1 : data0;
    assign granted   = (state_q == GRANT0) || (state_q == GRANT1);
    assign acc       = granted && own_valid && !gbe_tx_afull;
    assign at_limit  = (wcnt_q == CNT_W'(MAX_WORDS - 1));
    assign pkt_end   = acc && (own_eof || at_limit);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        wcnt_d     = wcnt_q;
        ip_d       = ip_q;
        port_d     = port_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        tx_eof_d   = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        trunc_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                // prio_q names the requester that wins a tie
                if (req0 && !(req1 && prio_q)) begin
                    state_d = GRANT0;
                    owner_d = 1'b0;
                    prio_d  = 1'b1;
                    ip_d    = ip0;
                    port_d  = port0;
                    wcnt_d  = '0;
                end else if (req1) begin
                    state_d = GRANT1;
                    owner_d = 1'b1;
                    prio_d  = 1'b0;
                    ip_d    = ip1;
                    port_d  = port1;
                    wcnt_d  = '0;
                end
            end
            GRANT0, GRANT1: begin
                grant0 = !owner_q;
                grant1 = owner_q;
                ready0 = !owner_q && !gbe_tx_afull;
                ready1 = owner_q && !gbe_tx_afull;
                if (acc) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = own_data;
                    wcnt_d     = wcnt_q + CNT_W'(1);
                    if (own_eof) begin
                        tx_eof_d = 1'b1;
                        state_d  = IDLE;
                    end else if (at_limit) begin
                        tx_eof_d  = 1'b1;
                        trunc_inc = 1'b1;
                        state_d   = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // drain the rest of the truncated packet regardless of backpressure
                grant0 = !owner_q;
                grant1 = owner_q;
                ready0 = !owner_q;
                ready1 = owner_q;
                if (own_valid && own_eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            wcnt_q      <= '0;
            ip_q        <= '0;
            port_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_eof_q    <= 1'b0;
            txvldctr_q  <= '0;
            trunc_ctr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            prio_q     <= prio_d;
            wcnt_q     <= wcnt_d;
            ip_q       <= ip_d;
            port_q     <= port_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_eof_q   <= tx_eof_d;
            if (ctr_rst)          txvldctr_q <= '0;
            else if (tx_valid_q)  txvldctr_q <= txvldctr_q + 32'd1;
            if (ctr_rst)          trunc_ctr_q <= '0;
            else if (trunc_inc && trunc_ctr_q != 16'hFFFF)
                trunc_ctr_q <= trunc_ctr_q + 16'd1;
        end
    end

`ifdef GBE_TX_ARBITER_PKTCNT_EN
    logic [31:0] pktcnt0_q, pktcnt1_q;

    always_ff @(posedge user_clk) begin
        if (!user_rst_n || ctr_rst) begin
            pktcnt0_q <= '0;
            pktcnt1_q <= '0;
        end else if (pkt_end) begin
            if (owner_q) pktcnt1_q <= pktcnt1_q + 32'd1;
            else         pktcnt0_q <= pktcnt0_q + 32'd1;
        end
    end

    assign pktcnt0 = pktcnt0_q;
    assign pktcnt1 = pktcnt1_q;
`else
    logic unused_pkt_end;
    assign unused_pkt_end = pkt_end;
`endif

    assign gbe_tx_data         = tx_data_q;
    assign gbe_tx_valid        = tx_valid_q;
    assign gbe_tx_end_of_frame = tx_eof_q;
    assign gbe_tx_dest_ip      = ip_q;
    assign gbe_tx_dest_port    = port_q;
    assign txvldctr            = txvldctr_q;
    assign trunc_ctr           = trunc_ctr_q;

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// Bench for gbe_tx_arbiter (MAX_WORDS=8): scoreboard of expected tx words plus cycle-exact sequences.
module tb_gbe_tx_arbiter;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          user_clk = 1'b0;
    logic          user_rst_n = 1'b0;
    logic          req0 = 0, req1 = 0, valid0 = 0, valid1 = 0, eof0 = 0, eof1 = 0;
    logic [DW-1:0] data0 = '0, data1 = '0;
    logic [31:0]   ip0 = '0, ip1 = '0;
    logic [15:0]   port0 = '0, port1 = '0;
    logic          gbe_tx_afull = 0, ctr_rst = 0;
    logic          grant0, grant1, ready0, ready1;
    logic [DW-1:0] gbe_tx_data;
    logic          gbe_tx_valid, gbe_tx_end_of_frame;
    logic [31:0]   gbe_tx_dest_ip, txvldctr;
    logic [15:0]   gbe_tx_dest_port, trunc_ctr;
`ifdef GBE_TX_ARBITER_PKTCNT_EN
    logic [31:0]   pktcnt0, pktcnt1;
`endif

    gbe_tx_arbiter #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
        .user_clk(user_clk), .user_rst_n(user_rst_n),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .valid0(valid0), .valid1(valid1), .eof0(eof0), .eof1(eof1),
        .ip0(ip0), .ip1(ip1), .port0(port0), .port1(port1),
        .grant0(grant0), .grant1(grant1), .ready0(ready0), .ready1(ready1),
        .gbe_tx_afull(gbe_tx_afull), .gbe_tx_data(gbe_tx_data), .gbe_tx_valid(gbe_tx_valid),
        .gbe_tx_end_of_frame(gbe_tx_end_of_frame), .gbe_tx_dest_ip(gbe_tx_dest_ip),
        .gbe_tx_dest_port(gbe_tx_dest_port), .ctr_rst(ctr_rst),
        .txvldctr(txvldctr), .trunc_ctr(trunc_ctr)
`ifdef GBE_TX_ARBITER_PKTCNT_EN
        , .pktcnt0(pktcnt0), .pktcnt1(pktcnt1)
`endif
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          eof;
        logic [31:0]   ip;
        logic [15:0]   port;
    } exp_t;

    typedef struct {
        logic r0;
        logic r1;
        logic exp_g1;
        int   nw;
    } arb_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] wd(input int n, input int k);
        logic [31:0] hi;
        hi = (n == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000;
        return {hi, 32'(k)};
    endfunction

    task automatic push(input int n, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.eof  = e;
        x.ip   = (n == 1) ? ip1 : ip0;
        x.port = (n == 1) ? port1 : port0;
        sb.push_back(x);
    endtask

    task automatic drive(input int n, input logic v, input logic [DW-1:0] d, input logic e);
        if (n == 1) begin valid1 = v; data1 = d; eof1 = e; end
        else        begin valid0 = v; data0 = d; eof0 = e; end
    endtask

    // Called with the grant already visible; returns one cycle after the eof word is accepted.
    task automatic send_pkt(input int n, input int nw, input int base, input int stall_at);
        int   k = 0;
        int   budget = 0;
        bit   stalled = 0;
        logic rdy;
        for (int i = 0; i < nw && i < MW; i++)
            push(n, wd(n, base + i), (i == nw - 1) || (i == MW - 1));
        while (k < nw && budget < 200) begin
            drive(n, 1'b1, wd(n, base + k), k == nw - 1);
            if (k == stall_at && !stalled) begin
                stalled = 1;
                gbe_tx_afull = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #3;
                    chk("stall_ready", (n == 1) ? ready1 : ready0, 1'b0);
                    chk("stall_grant", (n == 1) ? grant1 : grant0, 1'b1);
                    if (s > 0) chk("stall_no_valid", gbe_tx_valid, 1'b0);
                    @(posedge user_clk);
                    #1;
                end
                gbe_tx_afull = 1'b0;
            end
            #3;
            rdy = (n == 1) ? ready1 : ready0;
            @(posedge user_clk);
            #1;
            if (rdy) k++;
            budget++;
        end
        chk("send_complete", 64'(k), 64'(nw));
        drive(n, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        user_rst_n = 1'b0;
        tick();
        tick();
        user_rst_n = 1'b1;
    endtask

    always @(negedge user_clk) begin
        if (gbe_tx_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h with nothing expected", gbe_tx_data);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("tx_data", gbe_tx_data, x.data);
                chk("tx_eof", gbe_tx_end_of_frame, x.eof);
                chk("tx_ip", gbe_tx_dest_ip, x.ip);
                chk("tx_port", gbe_tx_dest_port, x.port);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        arb_t tbl[7];
        tbl[0] = '{1'b1, 1'b1, 1'b0, 2};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 3};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 2};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 2};

        do_reset();
        chk("rst_grant0", grant0, 0);
        chk("rst_grant1", grant1, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_valid", gbe_tx_valid, 0);
        chk("rst_eof", gbe_tx_end_of_frame, 0);
        chk("rst_data", gbe_tx_data, 0);
        chk("rst_txvldctr", txvldctr, 0);
        chk("rst_trunc", trunc_ctr, 0);

        // single 4-word packet
        ip0 = 32'hC0A8_0001; port0 = 16'h1234;
        ip1 = 32'hC0A8_0002; port1 = 16'h5678;
        req0 = 1;
        tick();
        chk("p4_grant0", grant0, 1);
        chk("p4_grant1", grant1, 0);
        chk("p4_idle_valid", gbe_tx_valid, 0);
        req0 = 0;
        for (int k = 0; k < 4; k++) push(0, wd(0, 10 + k), k == 3);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, wd(0, 10 + k), k == 3);
            tick();
            chk("p4_latency", gbe_tx_valid, 1);
        end
        drive(0, 1'b0, '0, 1'b0);
        chk("p4_release", grant0, 0);
        tick();
        chk("p4_txvldctr", txvldctr, 4);

        // simultaneous requests from reset
        do_reset();
        req0 = 1; req1 = 1;
        tick();
        chk("rr_first_g0", grant0, 1);
        chk("rr_first_g1", grant1, 0);
        chk("rr_first_ip", gbe_tx_dest_ip, 32'hC0A8_0001);
        chk("rr_first_port", gbe_tx_dest_port, 16'h1234);
        req0 = 0;
        send_pkt(0, 2, 100, -1);
        chk("rr_gap_g0", grant0, 0);
        chk("rr_gap_g1", grant1, 0);
        tick();
        chk("rr_second_g1", grant1, 1);
        chk("rr_second_ip", gbe_tx_dest_ip, 32'hC0A8_0002);
        chk("rr_second_port", gbe_tx_dest_port, 16'h5678);
        req1 = 0;
        send_pkt(1, 2, 200, -1);
        chk("rr_end_g1", grant1, 0);

        // truncation of a 10-word packet
        req0 = 1;
        tick();
        req0 = 0;
        send_pkt(0, 10, 300, -1);
        chk("trunc_idle", grant0, 0);
        chk("trunc_ctr", trunc_ctr, 1);

        // eof exactly on the limit is a normal end
        req0 = 1;
        tick();
        req0 = 0;
        send_pkt(0, MW, 400, -1);
        chk("limit_idle", grant0, 0);
        chk("limit_trunc", trunc_ctr, 1);

        // 3-cycle almost-full stall mid-packet
        req0 = 1;
        tick();
        req0 = 0;
        send_pkt(0, 6, 500, 2);
        chk("stall_end", grant0, 0);

        // txvldctr wrap
        tick();
        tick();
        dut.txvldctr_q = 32'hFFFF_FFFE;
        req0 = 1;
        tick();
        req0 = 0;
        send_pkt(0, 3, 600, -1);
        tick();
        chk("wrap_txvldctr", txvldctr, 1);

        // ctr_rst coinciding with a counted word, mid-packet
        req0 = 1;
        tick();
        req0 = 0;
        push(0, wd(0, 700), 1'b0);
        push(0, wd(0, 701), 1'b1);
        drive(0, 1'b1, wd(0, 700), 1'b0);
        tick();
        drive(0, 1'b1, wd(0, 701), 1'b1);
        ctr_rst = 1;
        tick();
        ctr_rst = 0;
        drive(0, 1'b0, '0, 1'b0);
        chk("ctrrst_txvldctr", txvldctr, 0);
        chk("ctrrst_trunc", trunc_ctr, 0);
        chk("ctrrst_fsm", grant0, 0);
        chk("ctrrst_word", gbe_tx_valid, 1);
        tick();
        chk("ctrrst_after", txvldctr, 1);

        // reset during word 2 of a 5-word packet
        req0 = 1;
        tick();
        req0 = 0;
        push(0, wd(0, 800), 1'b0);
        drive(0, 1'b1, wd(0, 800), 1'b0);
        tick();
        drive(0, 1'b1, wd(0, 801), 1'b0);
        user_rst_n = 0;
        tick();
        drive(0, 1'b0, '0, 1'b0);
        chk("mrst_grant0", grant0, 0);
        chk("mrst_ready0", ready0, 0);
        chk("mrst_valid", gbe_tx_valid, 0);
        chk("mrst_eof", gbe_tx_end_of_frame, 0);
        chk("mrst_data", gbe_tx_data, 0);
        chk("mrst_ip", gbe_tx_dest_ip, 0);
        chk("mrst_port", gbe_tx_dest_port, 0);
        chk("mrst_txvldctr", txvldctr, 0);
        user_rst_n = 1;
        tick();
        chk("mrst_post_valid", gbe_tx_valid, 0);
        chk("mrst_post_data", gbe_tx_data, 0);
        chk("mrst_post_grant", grant0, 0);

        // round-robin table from a fresh reset
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ip0 = 32'h0A00_0000 + 32'(i); port0 = 16'h1000 + 16'(i);
            ip1 = 32'h0B00_0000 + 32'(i); port1 = 16'h2000 + 16'(i);
            req0 = tbl[i].r0;
            req1 = tbl[i].r1;
            tick();
            chk("tbl_grant0", grant0, !tbl[i].exp_g1);
            chk("tbl_grant1", grant1, tbl[i].exp_g1);
            chk("tbl_ip", gbe_tx_dest_ip, tbl[i].exp_g1 ? ip1 : ip0);
            chk("tbl_port", gbe_tx_dest_port, tbl[i].exp_g1 ? port1 : port0);
            req0 = 0;
            req1 = 0;
            send_pkt(int'(tbl[i].exp_g1), tbl[i].nw, 1000 + 16 * i, -1);
            chk("tbl_idle", grant0 | grant1, 0);
        end

        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
